// File: rtl/pipe_mem_arbiter_if.sv
// Memory-side bus between the pipeline arbiter (master) and the memory (slave).
// Handshake: the master raises m_req together with m_addr/m_we/m_wdata and
// keeps all four stable until the slave returns a one-cycle m_ack, with m_rdata
// valid in that same cycle. The master drops m_req in the cycle after the ack.
// An ack while m_req is low carries no meaning.
interface pipe_mem_arbiter_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and the
// MEM stage. MEM normally wins, but after MAX_MEM_BURST back-to-back MEM grants
// with IF waiting, IF is served next. Each access runs grant -> wait for ack ->
// one response cycle -> back to IDLE. Every output except the stalls is a flop.
module pipe_mem_arbiter #(
  parameter int MAX_MEM_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_done,
  output logic               stall_if,
  output logic               stall_mem,
  output logic [1:0]         state_dbg,
  pipe_mem_arbiter_if.master mbus
);

  localparam int CW = $clog2(MAX_MEM_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] burst_cnt;
  logic          served_mem;  // the access in flight belongs to the MEM stage
  logic          rd_zero;     // MEM access was read+write: the load returns 0
  logic          m_req_q;
  logic          m_we_q;
  logic [31:0]   m_addr_q;
  logic [31:0]   m_wdata_q;

  logic mem_pend;
  logic if_starved;
  logic grant_mem;
  logic grant_if;
  logic ack_take;

  assign mem_pend   = mem_read | mem_write;
  assign if_starved = if_req && (burst_cnt == CW'(MAX_MEM_BURST));

  assign mbus.m_req   = m_req_q;
  assign mbus.m_we    = m_we_q;
  assign mbus.m_addr  = m_addr_q;
  assign mbus.m_wdata = m_wdata_q;
  assign state_dbg    = state;

  // A requester stops stalling only in the response cycle that serves it.
  assign stall_mem = mem_pend && !((state == RESP) && served_mem);
  assign stall_if  = if_req && !((state == RESP) && !served_mem);

  // Next-state and grant/ack decisions.
  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_pend && !if_starved) begin
          grant_mem = 1'b1;
          state_nxt = MEM_ACC;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (mbus.m_ack) begin
          ack_take  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus request, burst counter, captured read data and done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt  <= '0;
      served_mem <= 1'b0;
      rd_zero    <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_valid   <= 1'b0;
      mem_done   <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      if (grant_mem) begin
        m_req_q    <= 1'b1;
        m_we_q     <= mem_write;
        m_addr_q   <= mem_addr;
        m_wdata_q  <= mem_wdata;
        served_mem <= 1'b1;
        rd_zero    <= mem_read & mem_write;
        if (burst_cnt != CW'(MAX_MEM_BURST)) burst_cnt <= burst_cnt + 1'b1;
      end else if (grant_if) begin
        m_req_q    <= 1'b1;
        m_we_q     <= 1'b0;
        m_addr_q   <= if_addr;
        m_wdata_q  <= '0;
        served_mem <= 1'b0;
        rd_zero    <= 1'b0;
        burst_cnt  <= '0;
      end
      if (ack_take) begin
        m_req_q <= 1'b0;
        if (served_mem) begin
          mem_done <= 1'b1;
          if (!m_we_q)     mem_rdata <= mbus.m_rdata;
          else if (rd_zero) mem_rdata <= '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mbus.m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: reset values, a table of single-access vectors,
// hand-written sequences for burst fairness and reset mid-access, then random
// traffic checked against a transaction-level reference model.
module tb_pipe_mem_arbiter;
  localparam int MAX = 4;
  localparam int W   = 98;  // {is_mem, we, addr, wdata, rdata}
  localparam logic [1:0] IDLE_CODE = 2'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_read, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_valid, mem_done, stall_if, stall_mem;
  logic [1:0]  state_dbg;

  pipe_mem_arbiter_if bus();

  pipe_mem_arbiter #(.MAX_MEM_BURST(MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem), .state_dbg(state_dbg),
    .mbus(bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory responder ----------------
  logic        ack_drv, man_ack, resp_en;
  logic [31:0] rdata_drv, man_rdata;
  int          ack_lat;
  logic [31:0] mem_model [logic [31:0]];
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic        stable_err;

  assign bus.m_ack   = ack_drv | man_ack;
  assign bus.m_rdata = resp_en ? rdata_drv : man_rdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : ~a;
  endfunction

  initial begin
    int          wait_n;
    logic        acked;
    logic [64:0] first;
    ack_drv = 1'b0; rdata_drv = '0; wait_n = 0; acked = 1'b0;
    stable_err = 1'b0; first = '0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
    forever begin
      @(negedge clk);
      ack_drv = 1'b0;
      if (!bus.m_req || reset) begin
        wait_n = 0; acked = 1'b0;
      end else if (resp_en && !acked) begin
        if (wait_n == 0) first = {bus.m_we, bus.m_addr, bus.m_wdata};
        else if ({bus.m_we, bus.m_addr, bus.m_wdata} !== first) stable_err = 1'b1;
        if (wait_n == ack_lat) begin
          ack_drv   = 1'b1;
          rdata_drv = mem_rd(bus.m_addr);
          acked     = 1'b1;
          obs_we    = bus.m_we;
          obs_addr  = bus.m_addr;
          obs_wdata = bus.m_wdata;
          if (bus.m_we) mem_model[bus.m_addr] = bus.m_wdata;
        end else begin
          wait_n++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic stall_gap;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic is_mem, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
    exp_q.push_back({is_mem, we, addr, we ? wdata : 32'h0, rdata});
  endtask

  task automatic sb_check(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {mem_done, obs_we, obs_addr, obs_we ? obs_wdata : 32'h0,
           mem_done ? mem_rdata : if_rdata};
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: done pulse %0h with no expected access", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
    check({name, "_stable"}, stable_err, 1'b0);
    stable_err = 1'b0;
    check({name, "_one_done"}, if_valid & mem_done, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr,
                       input logic mw, input logic [31:0] ma, input logic [31:0] md);
    if_req = ir; if_addr = ia; mem_read = mr; mem_write = mw;
    mem_addr = ma; mem_wdata = md;
  endtask

  // Waits (bounded) for a done pulse; cyc counts negedges until it shows.
  task automatic wait_done(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (if_valid || mem_done) begin
        ok = 1'b1;
        break;
      end
      if ((if_req && !stall_if) || ((mem_read | mem_write) && !stall_mem)) stall_gap = 1'b1;
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: no done pulse within 60 cycles", name);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mrd, mwr;
    logic [31:0] maddr, mwdata;
    int          lat;
    logic        e_mem, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int          e_cyc;     // request-to-done cycles, grant cycle included
    logic [31:0] e2_rdata;  // data for the loser when both requested
  } vec_t;

  vec_t vecs[6];

  // ---------------- main test ----------------
  initial begin
    bit          ok;
    int          cyc;
    logic [9:0]  order;
    int          streak;
    logic        if_p, mem_p, mr, mw, win_mem;
    logic [31:0] ia, ma, md, rd, last_mem_rd;
    logic [31:0] ref_mem [logic [31:0]];
    int          op;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2,
                1'b0, 1'b0, 32'h100, 32'h0, 32'h0050_0093, 5, 32'h0};
    vecs[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 0,
                1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFE_0001, 3, 32'hFFFF_FEFB};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1,
                1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'hCAFE_0001, 4, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 3,
                1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 6, 32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 0,
                1'b1, 1'b1, 32'h80, 32'h1234_5678, 32'h0, 3, 32'h0};
    vecs[5] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1,
                1'b0, 1'b0, 32'h80, 32'h0, 32'h1234_5678, 4, 32'h0};

    mem_model[32'h100]  = 32'h0050_0093;
    mem_model[32'h2000] = 32'hCAFE_0001;
    resp_en = 1'b1; man_ack = 1'b0; man_rdata = '0; ack_lat = 0;
    stall_gap = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset values appear before any clock edge.
    reset = 1'b1;
    #2;
    check("rst_m_req", bus.m_req, 1'b0);
    check("rst_m_we", bus.m_we, 1'b0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_mem_done", mem_done, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_state", state_dbg, IDLE_CODE);
    check("rst_stalls", {stall_if, stall_mem}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single accesses, each applied in an IDLE cycle.
    for (int v = 0; v < 6; v++) begin
      ack_lat = vecs[v].lat;
      push_exp(vecs[v].e_mem, vecs[v].e_we, vecs[v].e_addr, vecs[v].e_wdata, vecs[v].e_rdata);
      drive(vecs[v].if_req, vecs[v].if_addr, vecs[v].mrd, vecs[v].mwr,
            vecs[v].maddr, vecs[v].mwdata);
      stall_gap = 1'b0;
      wait_done(ok, cyc);
      if (!ok) begin
        timeout_fail($sformatf("vec%0d_done", v));
        exp_q.delete();
      end else begin
        sb_check($sformatf("vec%0d_access", v));
        check($sformatf("vec%0d_latency", v), cyc + 1, vecs[v].e_cyc);
        check($sformatf("vec%0d_stall_wait", v), stall_gap, 1'b0);
        check($sformatf("vec%0d_stall_resp", v), {stall_if, stall_mem},
              vecs[v].e_mem ? {vecs[v].if_req, 1'b0} : {1'b0, vecs[v].mrd | vecs[v].mwr});
        if (vecs[v].e_mem) begin mem_read = 1'b0; mem_write = 1'b0; end
        else if_req = 1'b0;
        if (vecs[v].if_req && (vecs[v].mrd | vecs[v].mwr)) begin
          push_exp(1'b0, 1'b0, vecs[v].if_addr, 32'h0, vecs[v].e2_rdata);
          wait_done(ok, cyc);
          if (!ok) begin timeout_fail($sformatf("vec%0d_second", v)); exp_q.delete(); end
          else sb_check($sformatf("vec%0d_second", v));
          if_req = 1'b0;
        end
      end
      @(negedge clk);
    end

    // Burst fairness: both requesters pending throughout.
    ack_lat = 0;
    order = '0;
    drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h500, 32'h0);
    for (int k = 0; k < 10; k++) begin
      wait_done(ok, cyc);
      if (!ok) begin timeout_fail("burst_done"); break; end
      order = {order[8:0], mem_done};
      if (mem_done) mem_addr = mem_addr + 32'h4;
      else if_addr = if_addr + 32'h4;
    end
    check("burst_order", order, 10'b11110_11110);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a MEM access, then a stray ack after release.
    resp_en = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.m_req) break;
    end
    check("mid_rst_req_seen", bus.m_req, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_m_req", bus.m_req, 1'b0);
    check("mid_rst_bus", {bus.m_we, bus.m_addr, bus.m_wdata}, 65'h0);
    check("mid_rst_dones", {if_valid, mem_done}, 2'b00);
    check("mid_rst_rdata", {if_rdata, mem_rdata}, 64'h0);
    check("mid_rst_state", state_dbg, IDLE_CODE);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    man_rdata = 32'hBAD0_BAD0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("stray_ack_state", state_dbg, IDLE_CODE);
    check("stray_ack_outs", {bus.m_req, if_valid, mem_done}, 3'b000);
    check("stray_ack_rdata", {if_rdata, mem_rdata}, 64'h0);
    @(negedge clk);
    check("stray_ack_later", {state_dbg, if_valid, mem_done}, {IDLE_CODE, 2'b00});
    resp_en = 1'b1;

    // Random traffic against a transaction-level model. Arbitration rule:
    // MEM wins unless IF is waiting and MEM has already taken MAX grants in a
    // row since IF was last served.
    streak = 0; if_p = 1'b0; mem_p = 1'b0; mr = 1'b0; mw = 1'b0;
    ia = '0; ma = '0; md = '0; last_mem_rd = 32'h0;
    for (int t = 0; t < 80; t++) begin
      if (!if_p && $urandom_range(0, 2) != 0) begin
        if_p = 1'b1; ia = 32'h8000 | ($urandom & 32'h7C);
      end
      if (!mem_p && $urandom_range(0, 3) != 0) begin
        mem_p = 1'b1; op = $urandom_range(0, 2);
        mr = (op != 1); mw = (op != 0);
        ma = 32'h8000 | ($urandom & 32'h3C); md = $urandom;
      end
      if (!if_p && !mem_p) begin
        if_p = 1'b1; ia = 32'h8000 | ($urandom & 32'h7C);
      end
      drive(if_p, ia, mem_p & mr, mem_p & mw, ma, md);
      win_mem = mem_p && !(if_p && streak >= MAX);
      if (win_mem) begin
        if (mw) rd = mr ? 32'h0 : last_mem_rd;
        else    rd = ref_mem.exists(ma) ? ref_mem[ma] : ~ma;
        last_mem_rd = rd;
        if (mw) ref_mem[ma] = md;
        push_exp(1'b1, mw, ma, md, rd);
        streak = (streak + 1 > MAX) ? MAX : streak + 1;
      end else begin
        rd = ref_mem.exists(ia) ? ref_mem[ia] : ~ia;
        push_exp(1'b0, 1'b0, ia, 32'h0, rd);
        streak = 0;
      end
      ack_lat = $urandom_range(0, 3);
      wait_done(ok, cyc);
      if (!ok) begin timeout_fail($sformatf("rand%0d_done", t)); break; end
      sb_check($sformatf("rand%0d", t));
      check($sformatf("rand%0d_stall", t), {stall_if, stall_mem},
            {if_p && win_mem, mem_p && !win_mem});
      if (win_mem) mem_p = 1'b0;
      else         if_p  = 1'b0;
      drive(if_p, ia, mem_p & mr, mem_p & mw, ma, md);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter: MAX_MEM_BURST, default 4, max consecutive MEM-stage grants while IF waits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 if_req  in  1  fetch request; held until if_valid.
REQ-005 if_addr  in  32  fetch word address.
REQ-006 if_rdata  out  32  fetched instruction, valid while if_valid.
REQ-007 if_valid  out  1  one-cycle fetch-complete pulse.
REQ-008 mem_read, mem_write  in  1 each  MEM-stage controls from EX/MEM register.
REQ-009 mem_addr, mem_wdata  in  32 each  ALU result and store data from EX/MEM.
REQ-010 mem_rdata  out  32  load data, valid while mem_done.
REQ-011 mem_done  out  1  one-cycle MEM-access-complete pulse.
REQ-012 stall_if, stall_mem  out  1 each  hold IF stage / hold EX/MEM and earlier stages.
REQ-013 m_req, m_we  out  1 each  memory request and write-enable.
REQ-014 m_addr, m_wdata  out  32 each  memory address and write data.
REQ-015 m_ack  in  1  memory completion, any latency >= 1 cycle after m_req.
REQ-016 m_rdata  in  32  memory read data, valid with m_ack.

Function
REQ-017 FSM states IDLE, IF_ACC, MEM_ACC, RESP; every output except stall_* registered.
REQ-018 IDLE: MEM pending (mem_read|mem_write) and IF not starved -> MEM_ACC; else if_req -> IF_ACC; else stay.
REQ-019 IF starved = if_req high and burst counter == MAX_MEM_BURST; starved IF wins over MEM.
REQ-020 Burst counter: +1 per MEM grant, saturates at MAX_MEM_BURST, clears to 0 on any IF grant.
REQ-021 On grant, m_req=1 with m_addr, m_we, m_wdata registered the next cycle; all held stable until m_ack.
REQ-022 mem_write and mem_read both high: write performed, mem_rdata returns 0.
REQ-023 IF_ACC/MEM_ACC with m_ack=1: m_req drops next cycle; m_rdata captured; go RESP.
REQ-024 RESP: exactly one of if_valid or mem_done high for served requester; next state IDLE.
REQ-025 Minimum latency request-to-done = 3 cycles (grant, ack on first m_req cycle, RESP).
REQ-026 m_ack in IDLE or RESP ignored; no state change, no capture.
REQ-027 stall_mem combinational = MEM pending AND NOT (RESP with MEM served).
REQ-028 stall_if combinational = if_req AND NOT (RESP with IF served).
REQ-029 One bubble cycle (RESP then IDLE) between consecutive accesses; no request reissued after its done pulse.
REQ-030 mem_rdata/if_rdata hold last captured value outside done pulses.

Reset
REQ-031 reset asserted: state IDLE, counter 0, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_valid=0, mem_done=0, if_rdata=0, mem_rdata=0 immediately, without clock.
REQ-032 Reset mid-access abandons transaction; m_ack arriving after release while IDLE ignored per REQ-026.

Verification
REQ-033 IF only, if_addr=0x100, m_ack 2 cycles after m_req, m_rdata=0x00500093 -> if_valid pulse, if_rdata=0x00500093, stall_if low only in RESP.
REQ-034 if_req and mem_read same cycle, mem_addr=0x2000 -> MEM granted first, m_addr=0x2000, m_we=0; IF granted after RESP+IDLE.
REQ-035 mem_write, addr=0x40, wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF held until ack, mem_done pulse, mem_rdata unchanged.
REQ-036 MEM pending continuously plus if_req, MAX_MEM_BURST=4 -> exactly 4 MEM grants, then 1 IF grant, counter cleared.
REQ-037 Reset during MEM_ACC before ack, then ack arrives post-reset -> all outputs 0 at once, stray ack ignored, state IDLE.
REQ-038 mem_read and mem_write both high -> write issued (m_we=1), mem_rdata=0 at mem_done.
